trig_lut_arbiter: RTL and testbench
===================================

TRIG_LUT_ARBITER -- requirements
Module: trig_lut_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one trig LUT; fixed at 4 in this revision.
REQ-002 Parameter TIMEOUT, 15, maximum WAIT cycles before aborting a lookup.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  per-requester lookup request; bit i = requester i.
REQ-006 req_angle  input  64  flattened angles; bits [16i+15:16i] = requester i, 0-65535 maps to 0-2π.
REQ-007 req_ready  output  4  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 lut_start  output  1  one-cycle start pulse to the shared LUT.
REQ-009 lut_angle  output  16  angle driven to the LUT.
REQ-010 lut_cos, lut_sin  input  32 each  LUT results, 16.16 signed fixed-point.
REQ-011 lut_done  input  1  LUT result valid.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  2  index of the requester that owns the response.
REQ-015 rsp_cos, rsp_sin  output  32 each  registered results.
REQ-016 rsp_err  output  1  set when the lookup timed out.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE behaviour:
- When any req_valid bit is high, the block SHALL grant exactly one requester by round-robin.
- Search order starts at (last_grant+1) mod 4.
- req_ready SHALL be high only for the granted bit, combinationally, and only in IDLE.
REQ-020 On a transfer, the block SHALL capture the angle and the id, set last_grant to the id, and go to ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle: lut_start=1, lut_angle=captured angle, then go to WAIT.
REQ-022 lut_angle SHALL hold the captured angle through ISSUE and WAIT, and be 0 otherwise.
REQ-023 lut_start SHALL be 0 in all states except ISSUE.
REQ-024 WAIT, first case: when lut_done=1, the block SHALL register lut_cos/lut_sin into rsp_cos/rsp_sin, clear rsp_err and go to RESP.
REQ-025 WAIT, timeout case:
- A 4-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without lut_done.
- When the counter reaches TIMEOUT with lut_done still low, the block SHALL set rsp_err=1, load rsp_cos=rsp_sin=0 and go to RESP.
- lut_done on the same cycle as the counter reaching TIMEOUT SHALL take priority (normal response).
REQ-026 RESP: rsp_valid=1. rsp_id, rsp_cos, rsp_sin and rsp_err SHALL stay stable until rsp_ready=1, then the block goes to IDLE.
REQ-027 The block SHALL NOT accept a new request in the same cycle a response is consumed; minimum spacing is 4 cycles per lookup.
REQ-028 With a LUT that holds lut_done=1 and rsp_ready=1:
- transfer at cycle T;
- lut_start at T+1;
- rsp_valid at T+3;
- next req_ready at T+4.
REQ-029 Changes to req_valid or req_angle after the transfer SHALL NOT affect the response in flight.
REQ-030 Deasserting a request before it is granted SHALL be legal; such a request is not serviced.
REQ-031 Round-robin SHALL wrap 3 -> 0; a requester held continuously high SHALL be granted within 4 grants.
REQ-032 rsp_valid SHALL never be high outside RESP.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL go to IDLE and set last_grant=3, so requester 0 has first priority.
REQ-034 The same reset edge SHALL clear the WAIT counter and drive rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_err, lut_start, lut_angle and busy to 0.
REQ-035 While rst=1, req_ready SHALL be 0.
REQ-036 Reset in ISSUE, WAIT or RESP SHALL abandon the lookup with no response, even if rsp_valid was high.

Verification
REQ-037 Single request: req_valid=0001, angle0=0x4000, LUT done=1 -> rsp_valid at T+3, rsp_id=0, rsp_cos=lut_cos, rsp_err=0; exactly one lut_start pulse.
REQ-038 Contention: req_valid=1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; each response carries the matching angle's LUT result.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, all req_ready=0, lut_start=0; completes on the cycle rsp_ready rises.
REQ-040 Timeout: lut_done stuck 0 -> RESP after 15 WAIT cycles with rsp_err=1, rsp_cos=rsp_sin=0; done on the 15th WAIT cycle -> normal response.
REQ-041 Reset mid-WAIT: rst pulsed one cycle -> next cycle IDLE, rsp_valid=0; with req_valid=1010, the first grant goes to requester 1.
REQ-042 Angle change: requester 2 changes its angle the cycle after transfer -> response uses the originally captured angle on lut_angle.

Source files
------------

// File: rtl/trig_lut_arbiter.sv
// trig_lut_arbiter: round-robin arbiter that lets four requesters share one
// trig LUT, with a bounded wait on the LUT and a held response.
//
//   state | meaning
//   IDLE  | pick a requester round-robin, present req_ready to it
//   ISSUE | one-cycle lut_start with the captured angle
//   WAIT  | wait for lut_done, abort after TIMEOUT cycles
//   RESP  | hold the response until rsp_ready
module trig_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_angle,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   lut_start,
  output logic [15:0]            lut_angle,
  input  logic [31:0]            lut_cos,
  input  logic [31:0]            lut_sin,
  input  logic                   lut_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [31:0]            rsp_cos,
  output logic [31:0]            rsp_sin,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] angle_q, angle_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cos_q, cos_d;
  logic [31:0] sin_q, sin_d;
  logic        err_q, err_d;

  logic        gnt_found;
  logic [1:0]  gnt_id;
  logic [1:0]  cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Accept only the granted requester, only in IDLE and never during reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && gnt_found)
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
  end

  // Next-state and datapath updates for the lookup sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    angle_d      = angle_q;
    cnt_d        = cnt_q;
    cos_d        = cos_q;
    sin_d        = sin_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          angle_d      = req_angle[{gnt_id, 4'b0000} +: 16];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // lut_done wins over a timeout landing on the same cycle.
        if (lut_done) begin
          cos_d   = lut_cos;
          sin_d   = lut_sin;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(TIMEOUT - 1)) begin
            cos_d   = 32'd0;
            sin_d   = 32'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any lookup in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      id_q         <= 2'd0;
      angle_q      <= 16'd0;
      cnt_q        <= 4'd0;
      cos_q        <= 32'd0;
      sin_q        <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      angle_q      <= angle_d;
      cnt_q        <= cnt_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      err_q        <= err_d;
    end
  end

  assign lut_start = (state_q == ISSUE);
  assign lut_angle = (state_q == ISSUE || state_q == WAIT) ? angle_q : 16'd0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_cos   = cos_q;
  assign rsp_sin   = sin_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Bench for trig_lut_arbiter: vector table of lookups with a LUT model and a
// response scoreboard, plus a hand-written reset-mid-WAIT sequence.
module tb_trig_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_angle;
  logic [3:0]  req_ready;
  logic        lut_start;
  logic [15:0] lut_angle;
  logic [31:0] lut_cos, lut_sin;
  logic        lut_done;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_cos, rsp_sin;
  logic        rsp_err, busy;

  trig_lut_arbiter #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .lut_start(lut_start), .lut_angle(lut_angle),
    .lut_cos(lut_cos), .lut_sin(lut_sin), .lut_done(lut_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  function automatic logic [31:0] f_cos(input logic [15:0] a);
    return {a, ~a};
  endfunction
  function automatic logic [31:0] f_sin(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // LUT model: raises lut_done for one cycle on WAIT cycle lut_k (0 = never).
  int          lut_k = 1;
  int          wc = 0;
  logic        pend = 1'b0;
  logic [15:0] la = 16'd0;
  initial begin lut_done = 1'b0; lut_cos = 32'd0; lut_sin = 32'd0; end
  always @(negedge clk) begin
    cycles++;
    if (rst) begin pend = 1'b0; wc = 0; end
    else if (lut_start) begin pend = 1'b1; wc = 0; la = lut_angle; end
    else if (pend) wc++;
    lut_done = pend && (lut_k != 0) && (wc == lut_k);
    lut_cos  = f_cos(la);
    lut_sin  = f_sin(la);
    if (cycles > 5000) begin
      $display("FAIL watchdog: cycles %0d exceeded limit 5000", cycles);
      $fatal(1);
    end
  end

  typedef struct {
    logic [1:0]  id;
    logic [31:0] cos;
    logic [31:0] sin;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] base;
    int          k;
    int          hold;
    logic [1:0]  exp_id;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] build_angles(input logic [15:0] base);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = base + 16'(i * 16'h0101);
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    int starts;
    int gid;
    logic [15:0] orig;
    rsp_t e;
    rsp_t got;
    req_angle = build_angles(v.base);
    req_valid = v.mask;
    lut_k     = v.k;
    rsp_ready = (v.hold == 0);
    #1;
    n = 0;
    while ((req_valid & req_ready) == 4'd0 && n < 40) begin tick(); n++; end
    if ((req_valid & req_ready) == 4'd0) begin
      chk("grant_timeout", 64'(n), 64'd0);
      return;
    end
    gid = 0;
    for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
    chk("grant_id", 64'(gid), 64'(v.exp_id));
    chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
    orig  = req_angle[16*v.exp_id +: 16];
    e.id  = v.exp_id;
    e.err = v.exp_err;
    e.cos = v.exp_err ? 32'd0 : f_cos(orig);
    e.sin = v.exp_err ? 32'd0 : f_sin(orig);
    sb_q.push_back(e);
    tick();
    chk("issue_start", 64'(lut_start), 64'd1);
    chk("issue_angle", 64'(lut_angle), 64'(orig));
    req_angle = ~req_angle;
    lat = 1;
    starts = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
      if (lut_start) starts++;
    end
    chk("resp_latency", 64'(lat), 64'(v.exp_lat));
    chk("extra_lut_start", 64'(starts), 64'd0);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_start", 64'(lut_start), 64'd0);
      chk("hold_cos", 64'(rsp_cos), 64'(sb_q[0].cos));
      chk("hold_id", 64'(rsp_id), 64'(sb_q[0].id));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("consume_ready", 64'(req_ready), 64'd0);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      got.id = rsp_id; got.cos = rsp_cos; got.sin = rsp_sin; got.err = rsp_err;
      e = sb_q.pop_front();
      chk("rsp_id", 64'(got.id), 64'(e.id));
      chk("rsp_cos", 64'(got.cos), 64'(e.cos));
      chk("rsp_sin", 64'(got.sin), 64'(e.sin));
      chk("rsp_err", 64'(got.err), 64'(e.err));
    end
    tick();
    chk("post_valid", 64'(rsp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_angle", 64'(lut_angle), 64'd0);
    chk("post_ready_any", 64'(req_ready != 4'd0), 64'(req_valid != 4'd0));
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 16'h1000, 1,  0, 2'd0, 1'b0, 3};
    vecs[1]  = '{4'b1111, 16'h2000, 1,  0, 2'd1, 1'b0, 3};
    vecs[2]  = '{4'b1111, 16'h3000, 1,  0, 2'd2, 1'b0, 3};
    vecs[3]  = '{4'b1111, 16'h4400, 1,  0, 2'd3, 1'b0, 3};
    vecs[4]  = '{4'b1111, 16'h5000, 1,  0, 2'd0, 1'b0, 3};
    vecs[5]  = '{4'b0001, 16'h4000, 1,  0, 2'd0, 1'b0, 3};
    vecs[6]  = '{4'b0100, 16'h6000, 3,  5, 2'd2, 1'b0, 5};
    vecs[7]  = '{4'b1000, 16'h7000, 0,  0, 2'd3, 1'b1, 17};
    vecs[8]  = '{4'b0010, 16'h8000, 15, 0, 2'd1, 1'b0, 17};
    vecs[9]  = '{4'b0110, 16'h9000, 16, 0, 2'd2, 1'b1, 17};
    vecs[10] = '{4'b1001, 16'hA000, 2,  0, 2'd3, 1'b0, 4};
    vecs[11] = '{4'b1001, 16'hB000, 1,  2, 2'd0, 1'b0, 3};

    rst = 1'b1; req_valid = 4'b1111; req_angle = 64'd0; rsp_ready = 1'b1;
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0; req_valid = 4'd0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(lut_start), 64'd0);
    chk("rst_angle", 64'(lut_angle), 64'd0);
    chk("rst_rsp", 64'({rsp_id, rsp_err, rsp_cos}), 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset in the middle of WAIT abandons the lookup and restores priority.
    req_valid = 4'b0100; req_angle = build_angles(16'hC000); lut_k = 0;
    #1;
    chk("mid_grant", 64'(req_ready), 64'b0100);
    tick(); tick(); tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1; req_valid = 4'b1010;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid", 64'(rsp_valid), 64'd0);
    chk("mid_idle", 64'(busy), 64'd0);
    chk("mid_first_grant", 64'(req_ready), 64'b0010);
    run_vec('{4'b1010, 16'hD000, 1, 0, 2'd1, 1'b0, 3});

    req_valid = 4'd0;
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
